// File: rtl/cordic_pkg.sv
// Shared constants, helpers and FSM encoding for the iterative CORDIC divider.
package cordic_pkg;

    localparam int DEF_CORDIC_QUAN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int iters(input int quan);
        return quan + 1;
    endfunction

    function automatic longint sat_max(input int quan);
        return (longint'(2) << quan) - 1;
    endfunction

endpackage

// File: rtl/lin_vec_step.sv
// One linear-vectoring micro-rotation: drives yr toward zero, accumulating the quotient in zr.
module lin_vec_step
    import cordic_pkg::*;
#(
    parameter int W           = 34,
    parameter int CORDIC_QUAN = DEF_CORDIC_QUAN,
    parameter int KW          = 5
) (
    input  logic signed [W-1:0]  xr,
    input  logic signed [W-1:0]  yr,
    input  logic signed [W-1:0]  zr,
    input  logic        [KW-1:0] k,
    output logic signed [W-1:0]  yr_nxt,
    output logic signed [W-1:0]  zr_nxt
);

    logic signed [W-1:0] x_shift;
    logic signed [W-1:0] z_step;

    // NOTE: every output gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        x_shift = xr >>> k;
        z_step  = W'(1) << (KW'(CORDIC_QUAN) - k);
        if (yr[W-1]) begin
            yr_nxt = yr + x_shift;
            zr_nxt = zr - z_step;
        end else begin
            yr_nxt = yr - x_shift;
            zr_nxt = zr + z_step;
        end
    end

endmodule

// File: rtl/cordic_div_ctrl.sv
// Iterative signed divider q = y / x in Q(CORDIC_QUAN): operand normalisation, range check,
// a time-shared micro-rotation step and valid/ready handshakes on both sides.
module cordic_div_ctrl
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CORDIC_QUAN = DEF_CORDIC_QUAN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  ovf_out
);

    localparam int W     = DATA_WIDTH + 2;
    localparam int MSB   = DATA_WIDTH - 1;
    localparam int ITERS = iters(CORDIC_QUAN);
    localparam int KW    = $clog2(ITERS + 1);

    localparam logic [KW-1:0]         K_LAST = KW'(CORDIC_QUAN);
    localparam logic [DATA_WIDTH-1:0] Q_POS  = DATA_WIDTH'(sat_max(CORDIC_QUAN));
    localparam logic [DATA_WIDTH-1:0] Q_NEG  = -Q_POS;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state;
    logic signed [W-1:0] xr, yr, zr;
    logic signed [W-1:0] yr_nxt, zr_nxt;
    logic [KW-1:0]       k;
    logic                ovf, sgn;

    logic signed [W-1:0] x_ext, y_ext, x_norm, y_norm, y_abs;
    logic                x_zero, ovf_cap, sgn_cap;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // A negative divisor flips both operands so xr is never negative and the quotient is unchanged.
    always_comb begin
        x_ext   = {{2{x_in[MSB]}}, x_in};
        y_ext   = {{2{y_in[MSB]}}, y_in};
        x_norm  = x_in[MSB] ? -x_ext : x_ext;
        y_norm  = x_in[MSB] ? -y_ext : y_ext;
        y_abs   = y_in[MSB] ? -y_ext : y_ext;
        x_zero  = (x_in == '0);
        ovf_cap = x_zero || (y_abs >= (x_norm <<< 1));
        sgn_cap = x_zero ? y_in[MSB] : (y_in[MSB] ^ x_in[MSB]);
    end

    lin_vec_step #(
        .W           (W),
        .CORDIC_QUAN (CORDIC_QUAN),
        .KW          (KW)
    ) u_step (
        .xr     (xr),
        .yr     (yr),
        .zr     (zr),
        .k      (k),
        .yr_nxt (yr_nxt),
        .zr_nxt (zr_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            xr      <= '0;
            yr      <= '0;
            zr      <= '0;
            k       <= '0;
            ovf     <= 1'b0;
            sgn     <= 1'b0;
            q_out   <= '0;
            ovf_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        xr    <= x_norm;
                        yr    <= y_norm;
                        zr    <= '0;
                        k     <= '0;
                        ovf   <= ovf_cap;
                        sgn   <= sgn_cap;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    yr <= yr_nxt;
                    zr <= zr_nxt;
                    k  <= k + KW'(1);
                    // The final iteration's zr is taken straight from the step output.
                    if (k == K_LAST) begin
                        state   <= ST_DONE;
                        ovf_out <= ovf;
                        q_out   <= ovf ? (sgn ? Q_NEG : Q_POS) : zr_nxt[DATA_WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_div_ctrl.sv
// Self-checking bench for cordic_div_ctrl: directed vectors plus an arithmetic reference model.
module tb_cordic_div_ctrl;

    localparam int     DW   = 32;
    localparam int     Q    = 16;
    localparam int     LAT  = Q + 1;
    localparam longint SMAX = (longint'(2) << Q) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x_in = '0;
    logic [DW-1:0] y_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] q_out;
    logic          ovf_out;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cycle    = 0;

    typedef struct {
        logic   ovf;
        real    q;
        real    tol;
        longint acc_cycle;
    } exp_t;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        longint        q;
        logic          ovf;
        int            tol;
        string         name;
    } vec_t;

    exp_t exp_q[$];

    cordic_div_ctrl #(.DATA_WIDTH(DW), .CORDIC_QUAN(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input real act, input real exp, input real tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0f, expected %0f +/- %0f", name, act, exp, tol);
        end
    endtask

    // Reference: real-valued quotient, or the saturated value when |y| >= 2|x| or x == 0.
    function automatic exp_t model(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        exp_t   e;
        longint ax, ay;
        logic   neg;
        ax = (x < 0) ? -longint'(x) : longint'(x);
        ay = (y < 0) ? -longint'(y) : longint'(y);
        e.acc_cycle = 0;
        e.ovf = (x == 0) || (ay >= 2 * ax);
        if (e.ovf) begin
            neg   = (x == 0) ? (y < 0) : ((y < 0) != (x < 0));
            e.q   = neg ? -real'(SMAX) : real'(SMAX);
            e.tol = 0.0;
        end else begin
            e.q   = real'(longint'(y)) * real'(longint'(1) << Q) / real'(longint'(x));
            e.tol = 2.0;
        end
        return e;
    endfunction

    // Compare process: every accept feeds the model, every valid output is checked against it.
    logic   prev_valid = 1'b0;
    longint last_acc   = -1;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
            last_acc   = -1;
        end else begin
            if (out_valid) begin
                check("in_ready low while out_valid", in_ready, 0);
                check("result pending for out_valid", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check("model ovf_out", ovf_out, e.ovf);
                    check_near("model q_out", $itor($signed(q_out)), e.q, e.tol);
                    if (!prev_valid) check("model latency", cycle - e.acc_cycle, LAT);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                e = model(x_in, y_in);
                e.acc_cycle = cycle + 1;
                if (last_acc >= 0)
                    check("initiation interval >= 19", (e.acc_cycle - last_acc) >= LAT + 2, 1);
                last_acc = e.acc_cycle;
                exp_q.push_back(e);
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int t = 0;
        x_in = x;
        y_in = y;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("send sees in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [DW-1:0] q, output logic o, output int t);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        q = q_out;
        o = ovf_out;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[11];
        logic [DW-1:0] q, q_hold;
        logic          o;
        int            t, seen;
        longint        mag, ymag, ylim;

        vecs[0]  = '{32'h0002_0000, 32'h0001_0000,  32768, 1'b0, 2, "1/2"};
        vecs[1]  = '{32'h0002_0000, 32'hFFFD_0000, -98304, 1'b0, 2, "-3/2"};
        vecs[2]  = '{32'hFFFC_0000, 32'h0001_0000, -16384, 1'b0, 2, "1/-4"};
        vecs[3]  = '{32'h0002_0000, 32'h0005_0000, 131071, 1'b1, 0, "5/2 ovf"};
        vecs[4]  = '{32'h0001_0000, 32'h0001_FFFF, 131071, 1'b0, 2, "just below 2x"};
        vecs[5]  = '{32'h0001_0000, 32'h0002_0000, 131071, 1'b1, 0, "exactly 2x"};
        vecs[6]  = '{32'h0001_0000, 32'hFFFE_0000, -131071, 1'b1, 0, "exactly -2x"};
        vecs[7]  = '{32'h8000_0000, 32'h0000_0000, 0, 1'b0, 2, "0/most-negative"};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 65536, 1'b0, 2, "max/max"};
        vecs[9]  = '{32'hFFFE_0000, 32'hFFFF_0000, 32768, 1'b0, 2, "-1/-2"};
        vecs[10] = '{32'h0000_0000, 32'hFFFF_0000, -131071, 1'b1, 0, "-1/0 ovf"};

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset q_out", q_out, 0);
        check("reset ovf_out", ovf_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        foreach (vecs[i]) begin
            send(vecs[i].x, vecs[i].y);
            wait_result(q, o, t);
            check({vecs[i].name, " latency"}, t, LAT);
            check_near({vecs[i].name, " q_out"}, $itor($signed(q)), real'(vecs[i].q), real'(vecs[i].tol));
            check({vecs[i].name, " ovf_out"}, o, vecs[i].ovf);
            take();
        end

        // Reset in the middle of RUN discards the division
        send(32'h0002_0000, 32'h0001_0000);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid-run reset in_ready", in_ready, 1);
        check("mid-run reset out_valid", out_valid, 0);
        check("mid-run reset q_out", q_out, 0);
        check("mid-run reset ovf_out", ovf_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("in_ready after reset release", in_ready, 1);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no out_valid after mid-run reset", seen, 0);
        send(32'h0004_0000, 32'h0001_0000);
        wait_result(q, o, t);
        check("post-reset latency", t, LAT);
        check_near("post-reset q_out", $itor($signed(q)), 16384.0, 2.0);
        take();

        // Back-pressure in DONE with the next operand already waiting
        send(32'h0004_0000, 32'h0003_0000);
        x_in = 32'h0001_0000;
        y_in = 32'hFFFF_8000;
        in_valid = 1'b1;
        wait_result(q_hold, o, t);
        check_near("hold q_out", $itor($signed(q_hold)), 49152.0, 2.0);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold q_out stable", q_out, q_hold);
            check("hold out_valid", out_valid, 1);
            check("hold in_ready low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle after take", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("waiting operand accepted", in_ready, 0);
        wait_result(q, o, t);
        check("waiting operand latency", t, LAT);
        check_near("waiting operand q_out", $itor($signed(q)), -32768.0, 2.0);
        take();

        // Back-to-back random in-range operands, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) mag = longint'($urandom_range(1, 200)) << Q;
            else            mag = longint'($urandom_range(32'h0040_0000, 32'h4000_0000));
            ylim = 2 * mag - 1;
            if (ylim > 64'h7FFF_FFFF) ylim = 64'h7FFF_FFFF;
            ymag = longint'($urandom_range(0, 32'(ylim)));
            send($urandom_range(0, 1) ? DW'(-mag) : DW'(mag),
                 $urandom_range(0, 1) ? DW'(-ymag) : DW'(ymag));
            wait_result(q, o, t);
            check("random latency", t, LAT);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("all results delivered", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
